maze_nav_ctrl: RTL and testbench

//  Parametrised line-maze navigation FSM. Next generation of the fpga_top solver:
//  N-channel IR input, selectable right-/left-hand rule, goal detection,

---
 rtl/maze_pkg.sv | 24 ++
 rtl/maze_nav_ctrl_debounce.sv | 32 +++
 rtl/maze_nav_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_maze_nav_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings and motion constants for the line-maze navigation controller.
package maze_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_SEARCH      = 4'd1,
        ST_FOLLOW      = 4'd2,
        ST_ADJUST      = 4'd3,
        ST_PROBE       = 4'd4,
        ST_TURN        = 4'd5,
        ST_TURN_AROUND = 4'd6,
        ST_BACKOFF     = 4'd7,
        ST_STEP_WAIT   = 4'd8,
        ST_GOAL        = 4'd9,
        ST_FAULT       = 4'd10
    } state_t;

    localparam logic [15:0] FAST      = 16'd360;
    localparam logic [15:0] SLOW      = 16'd180;
    localparam logic [15:0] DEG_OUTER = 16'd240;
    localparam logic [15:0] DEG_INNER = 16'd120;
    localparam logic [15:0] DEG_UTURN = 16'd360;

endpackage

// File: rtl/maze_nav_ctrl_debounce.sv
// Hold-time debouncer: output follows the raw input only after it has
// differed from the current output for DB_CYCLES consecutive cycles.
module maze_nav_ctrl_debounce #(
    parameter int unsigned DB_CYCLES = 1600000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic db_o
);
    localparam int unsigned W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [W-1:0] cnt_q;
    logic         db_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (raw_i == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == W'(DB_CYCLES - 1)) begin
            db_q  <= raw_i;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/maze_nav_ctrl.sv
// Line-maze navigation FSM: wall-follow rule, goal detection, junction/dead-end
// counting and step-handshake supervision. Issues motion commands only.
module maze_nav_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned DB_CYCLES   = 1600000,
    parameter int unsigned GOAL_CYCLES = 8000000,
    parameter int unsigned STEP_TMO    = 48000000,
    parameter int unsigned LOST_MAX    = 3,
    parameter int unsigned CW          = 8
) (
    input  logic            WF_CLK,
    input  logic            rst,
    input  logic            start,
    input  logic            bump,
    input  logic            hand_sel,
    input  logic [N_CH-1:0] ir_color,
    input  logic            step_done,
    output logic            step_start,
    output logic [15:0]     step_degL,
    output logic [15:0]     step_degR,
    output logic            drive_en,
    output logic            drive_sel,
    output logic [15:0]     speedL,
    output logic [15:0]     speedR,
    output logic            dirL,
    output logic            dirR,
    output logic [CW-1:0]   junction_cnt,
    output logic [CW-1:0]   deadend_cnt,
    output logic            goal,
    output logic            fault,
    output logic [3:0]      state
);
    localparam int unsigned H    = N_CH / 2;
    localparam int unsigned SW   = $clog2(H + 1);
    localparam int unsigned TMAX = (GOAL_CYCLES > STEP_TMO) ? GOAL_CYCLES : STEP_TMO;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned LW   = $clog2(LOST_MAX + 1);

    function automatic logic [SW-1:0] popcnt(input logic [H-1:0] v);
        logic [SW-1:0] s;
        logic [H-1:0]  t;
        s = '0;
        t = v;
        for (int unsigned i = 0; i < H; i++) begin
            s = s + SW'(t[0]);
            t = t >> 1;
        end
        return s;
    endfunction

    state_t         state_q, state_d, ret_q, ret_d;
    logic           hand_q, hand_d, goal_q, goal_d, fault_q, fault_d;
    logic [CW-1:0]  jcnt_q, jcnt_d, dcnt_q, dcnt_d;
    logic [LW-1:0]  lost_run_q, lost_run_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           step_start_q, step_start_d, en_q, en_d, sel_q, sel_d;
    logic           dir_l_q, dir_l_d, dir_r_q, dir_r_d;
    logic [15:0]    deg_l_q, deg_l_d, deg_r_q, deg_r_d;
    logic [15:0]    spd_l_q, spd_l_d, spd_r_q, spd_r_d;

    logic           on_raw, lost_raw, pos_raw, allblk, hand_open;
    logic           on_db, lost_db, pos_db;
    logic [H-1:0]   left_rev;
    logic [SW-1:0]  sum_l, sum_r;

    assign left_rev  = {<<{ir_color[N_CH-1:H]}};
    assign on_raw    = ir_color[H] | ir_color[H-1];
    assign lost_raw  = (ir_color == '0);
    assign allblk    = &ir_color;
    assign pos_raw   = on_raw & (ir_color[H-1:0] == left_rev);
    assign hand_open = hand_q ? (&ir_color[N_CH-1:H]) : (&ir_color[H-1:0]);
    assign sum_l     = popcnt(ir_color[N_CH-1:H]);
    assign sum_r     = popcnt(ir_color[H-1:0]);

    maze_nav_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_on (
        .clk_i(WF_CLK), .rst_i(rst), .raw_i(on_raw), .db_o(on_db));
    maze_nav_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lost (
        .clk_i(WF_CLK), .rst_i(rst), .raw_i(lost_raw), .db_o(lost_db));
    maze_nav_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pos (
        .clk_i(WF_CLK), .rst_i(rst), .raw_i(pos_raw), .db_o(pos_db));

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        hand_d       = hand_q;
        jcnt_d       = jcnt_q;
        dcnt_d       = dcnt_q;
        lost_run_d   = lost_run_q;
        timer_d      = timer_q;
        goal_d       = goal_q;
        fault_d      = fault_q;
        step_start_d = 1'b0;
        deg_l_d      = deg_l_q;
        deg_r_d      = deg_r_q;
        dir_l_d      = dir_l_q;
        dir_r_d      = dir_r_q;
        en_d         = 1'b0;
        sel_d        = 1'b0;
        spd_l_d      = '0;
        spd_r_d      = '0;

        if (bump && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d    = ST_SEARCH;
                    hand_d     = hand_sel;
                    jcnt_d     = '0;
                    dcnt_d     = '0;
                    lost_run_d = '0;
                    goal_d     = 1'b0;
                    fault_d    = 1'b0;
                end
                ST_SEARCH: if (on_db) state_d = ST_FOLLOW;
                ST_FOLLOW: begin
                    // lost_run only clears on a centred reacquire; otherwise the
                    // consecutive turn-around limit could never be reached.
                    if (allblk) begin
                        state_d = ST_PROBE;
                        timer_d = '0;
                    end else if (hand_open) state_d = ST_TURN;
                    else if (pos_db)        lost_run_d = '0;
                    else if (!lost_db)      state_d = ST_ADJUST;
                    else                    state_d = ST_TURN_AROUND;
                end
                ST_ADJUST: if (sum_l == sum_r) state_d = ST_FOLLOW;
                ST_PROBE: begin
                    if (!allblk) state_d = ST_TURN;
                    else if (timer_q == TW'(GOAL_CYCLES - 1)) begin
                        state_d = ST_GOAL;
                        goal_d  = 1'b1;
                    end else timer_d = timer_q + 1'b1;
                end
                ST_TURN: begin
                    step_start_d = 1'b1;
                    deg_l_d      = hand_q ? DEG_INNER : DEG_OUTER;
                    deg_r_d      = hand_q ? DEG_OUTER : DEG_INNER;
                    dir_l_d      = hand_q;
                    dir_r_d      = ~hand_q;
                    jcnt_d       = (jcnt_q == '1) ? jcnt_q : jcnt_q + 1'b1;
                    ret_d        = ST_FOLLOW;
                    timer_d      = '0;
                    state_d      = ST_STEP_WAIT;
                end
                ST_TURN_AROUND: begin
                    dcnt_d     = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
                    lost_run_d = lost_run_q + 1'b1;
                    if (lost_run_q + 1'b1 == LW'(LOST_MAX)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        step_start_d = 1'b1;
                        deg_l_d      = DEG_UTURN;
                        deg_r_d      = DEG_UTURN;
                        dir_l_d      = 1'b0;
                        dir_r_d      = 1'b1;
                        ret_d        = ST_BACKOFF;
                        timer_d      = '0;
                        state_d      = ST_STEP_WAIT;
                    end
                end
                ST_BACKOFF: if (lost_db) state_d = ST_SEARCH;
                ST_STEP_WAIT: begin
                    if (!step_start_q && step_done) state_d = ret_q;
                    else if (timer_q == TW'(STEP_TMO - 1)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else timer_d = timer_q + 1'b1;
                end
                ST_GOAL, ST_FAULT: if (start) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_d)
            ST_SEARCH, ST_FOLLOW, ST_PROBE, ST_ADJUST, ST_BACKOFF: begin
                en_d    = 1'b1;
                spd_l_d = (state_d == ST_SEARCH || state_d == ST_FOLLOW) ? FAST : SLOW;
                spd_r_d = spd_l_d;
                dir_l_d = (state_d == ST_BACKOFF) || (state_d == ST_ADJUST && sum_l > sum_r);
                dir_r_d = (state_d == ST_BACKOFF) || (state_d == ST_ADJUST && !(sum_l > sum_r));
            end
            ST_TURN, ST_TURN_AROUND, ST_STEP_WAIT: sel_d = 1'b1;
            default: begin
                dir_l_d = 1'b0;
                dir_r_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;      ret_q <= ST_IDLE;
            hand_q <= 1'b0;          goal_q <= 1'b0;      fault_q <= 1'b0;
            jcnt_q <= '0;            dcnt_q <= '0;
            lost_run_q <= '0;        timer_q <= '0;
            step_start_q <= 1'b0;    en_q <= 1'b0;        sel_q <= 1'b0;
            dir_l_q <= 1'b0;         dir_r_q <= 1'b0;
            deg_l_q <= '0;           deg_r_q <= '0;
            spd_l_q <= '0;           spd_r_q <= '0;
        end else begin
            state_q <= state_d;      ret_q <= ret_d;
            hand_q <= hand_d;        goal_q <= goal_d;    fault_q <= fault_d;
            jcnt_q <= jcnt_d;        dcnt_q <= dcnt_d;
            lost_run_q <= lost_run_d; timer_q <= timer_d;
            step_start_q <= step_start_d; en_q <= en_d;   sel_q <= sel_d;
            dir_l_q <= dir_l_d;      dir_r_q <= dir_r_d;
            deg_l_q <= deg_l_d;      deg_r_q <= deg_r_d;
            spd_l_q <= spd_l_d;      spd_r_q <= spd_r_d;
        end
    end

    assign step_start   = step_start_q;
    assign step_degL    = deg_l_q;
    assign step_degR    = deg_r_q;
    assign drive_en     = en_q;
    assign drive_sel    = sel_q;
    assign speedL       = spd_l_q;
    assign speedR       = spd_r_q;
    assign dirL         = dir_l_q;
    assign dirR         = dir_r_q;
    assign junction_cnt = jcnt_q;
    assign deadend_cnt  = dcnt_q;
    assign goal         = goal_q;
    assign fault        = fault_q;
    assign state        = state_q;

endmodule

// File: tb/tb_maze_nav_ctrl.sv
// Bench for maze_nav_ctrl: step commands checked against a scoreboard queue,
// state/flag/counter behaviour checked directly with short timing parameters.
module tb_maze_nav_ctrl;
    import maze_pkg::*;

    localparam int unsigned N_CH = 8;
    localparam int unsigned DB   = 4;
    localparam int unsigned GC   = 20;
    localparam int unsigned TMO  = 30;
    localparam int unsigned LM   = 3;
    localparam int unsigned CW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, bump = 1'b0, hand_sel = 1'b0, step_done = 1'b0;
    logic [N_CH-1:0] ir = '0;
    logic step_start, drive_en, drive_sel, dirL, dirR, goal, fault;
    logic [15:0] step_degL, step_degR, speedL, speedR;
    logic [CW-1:0] junction_cnt, deadend_cnt;
    logic [3:0] state;

    always #5 clk = ~clk;

    maze_nav_ctrl #(
        .N_CH(N_CH), .DB_CYCLES(DB), .GOAL_CYCLES(GC),
        .STEP_TMO(TMO), .LOST_MAX(LM), .CW(CW)
    ) dut (
        .WF_CLK(clk), .rst(rst), .start(start), .bump(bump), .hand_sel(hand_sel),
        .ir_color(ir), .step_done(step_done), .step_start(step_start),
        .step_degL(step_degL), .step_degR(step_degR), .drive_en(drive_en),
        .drive_sel(drive_sel), .speedL(speedL), .speedR(speedR), .dirL(dirL),
        .dirR(dirR), .junction_cnt(junction_cnt), .deadend_cnt(deadend_cnt),
        .goal(goal), .fault(fault), .state(state)
    );

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        dl;
        logic        dr;
    } step_t;

    step_t exp_q[$];
    int total = 0, bad = 0, n_steps = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_step(input logic [15:0] l, input logic [15:0] r,
                               input logic dl, input logic dr);
        exp_q.push_back('{l: l, r: r, dl: dl, dr: dr});
    endtask

    always @(negedge clk) begin : sb_mon
        step_t e;
        if (!rst && step_start) begin
            n_steps++;
            chk_eq("step_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_eq("step_degL", step_degL, e.l);
                chk_eq("step_degR", step_degR, e.r);
                chk_eq("step_dirL", dirL, e.dl);
                chk_eq("step_dirR", dirR, e.dr);
            end
        end
    end

    task automatic wait_state(input state_t s, input int unsigned budget, input string tag);
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) break;
        end
        chk_eq(tag, state, s);
    endtask

    task automatic wait_step(input string tag);
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_start) break;
        end
        chk_eq(tag, step_start, 1);
    endtask

    task automatic done_step();
        @(negedge clk);
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
    endtask

    task automatic restart(input logic h);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bump = 1'b0; step_done = 1'b0;
        hand_sel = h; ir = 8'h18; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("search_entry", state, ST_SEARCH);
        wait_state(ST_FOLLOW, 20, "follow_entry");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("rst_state", state, ST_IDLE);
        chk_eq("rst_drive_en", drive_en, 0);
        chk_eq("rst_speedL", speedL, 0);
        chk_eq("rst_step_start", step_start, 0);
        chk_eq("rst_jcnt", junction_cnt, 0);
        chk_eq("rst_goal_fault", {goal, fault}, 0);

        // Acquire track and cruise
        restart(1'b0);
        chk_eq("fol_speedL", speedL, 360);
        chk_eq("fol_speedR", speedR, 360);
        chk_eq("fol_dirs", {dirL, dirR}, 0);
        chk_eq("fol_drive", {drive_en, drive_sel}, 2'b10);

        // Right-hand junction
        expect_step(16'd240, 16'd120, 1'b0, 1'b1);
        ir = 8'h0F;
        wait_step("rturn_pulse");
        ir = 8'h18;
        chk_eq("rturn_jcnt", junction_cnt, 1);
        chk_eq("rturn_drive", {drive_en, drive_sel}, 2'b01);
        step_done = 1'b1;
        @(negedge clk);
        chk_eq("done_on_pulse_ignored", state, ST_STEP_WAIT);
        step_done = 1'b0;
        done_step();
        chk_eq("rturn_return", state, ST_FOLLOW);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk_eq("start_ignored", state, ST_FOLLOW);

        // Left-hand rule: right-open junction is not taken, left-open is
        restart(1'b1);
        n0 = n_steps;
        ir = 8'h0F;
        repeat (3) @(negedge clk);
        chk_eq("lhand_no_turn_state", state, ST_FOLLOW);
        chk_eq("lhand_no_turn_steps", n_steps, n0);
        chk_eq("lhand_no_turn_jcnt", junction_cnt, 0);
        expect_step(16'd120, 16'd240, 1'b1, 1'b0);
        ir = 8'hF8;
        wait_step("lturn_pulse");
        ir = 8'h18;
        chk_eq("lturn_jcnt", junction_cnt, 1);
        done_step();
        chk_eq("lturn_return", state, ST_FOLLOW);

        // Goal: all black held long enough
        restart(1'b0);
        ir = 8'hFF;
        wait_state(ST_PROBE, 5, "probe_entry");
        chk_eq("probe_speed", speedL, 180);
        wait_state(ST_GOAL, GC + 10, "goal_entry");
        chk_eq("goal_flag", goal, 1);
        chk_eq("goal_motors", {drive_en, speedL, speedR}, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("goal_to_idle", state, ST_IDLE);
        chk_eq("goal_sticky", goal, 1);

        // Crossing: all black drops early -> hand-side turn
        restart(1'b0);
        ir = 8'hFF;
        wait_state(ST_PROBE, 5, "probe2_entry");
        repeat (3) @(negedge clk);
        expect_step(16'd240, 16'd120, 1'b0, 1'b1);
        ir = 8'h18;
        wait_step("probe_turn_pulse");
        chk_eq("probe_turn_jcnt", junction_cnt, 1);
        chk_eq("probe_turn_nogoal", goal, 0);
        done_step();
        chk_eq("probe_turn_return", state, ST_FOLLOW);

        // Repeated dead ends without a centred reacquire
        restart(1'b0);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin
                ir = 8'h10;
                wait_state(ST_ADJUST, 20, "reacq_adjust");
                chk_eq("adjust_dirs", {dirL, dirR}, 2'b10);
            end
            n0 = n_steps;
            if (k < 3) expect_step(16'd360, 16'd360, 1'b0, 1'b1);
            ir = 8'h00;
            if (k < 3) begin
                wait_step("uturn_pulse");
                chk_eq("uturn_dcnt", deadend_cnt, k);
                @(negedge clk);
                step_done = 1'b1;
                @(negedge clk);
                step_done = 1'b0;
                if (k == 1) begin
                    chk_eq("backoff_state", state, ST_BACKOFF);
                    chk_eq("backoff_dirs", {dirL, dirR}, 2'b11);
                    chk_eq("backoff_speed", speedL, 180);
                end
                wait_state(ST_SEARCH, 10, "backoff_to_search");
            end else begin
                wait_state(ST_FAULT, 40, "lost_fault");
                chk_eq("lost_fault_flag", fault, 1);
                chk_eq("lost_fault_dcnt", deadend_cnt, 3);
                chk_eq("lost_fault_nostep", n_steps, n0);
                chk_eq("lost_fault_motors", {drive_en, drive_sel}, 0);
            end
        end

        // Step handshake timeout
        restart(1'b0);
        expect_step(16'd240, 16'd120, 1'b0, 1'b1);
        ir = 8'h0F;
        wait_step("tmo_pulse");
        ir = 8'h18;
        repeat (TMO - 1) @(negedge clk);
        chk_eq("tmo_still_waiting", state, ST_STEP_WAIT);
        @(negedge clk);
        chk_eq("tmo_fault_state", state, ST_FAULT);
        chk_eq("tmo_fault_flag", fault, 1);

        // Bump during a step
        restart(1'b0);
        expect_step(16'd240, 16'd120, 1'b0, 1'b1);
        ir = 8'h0F;
        wait_step("bump_pulse");
        ir = 8'h18;
        repeat (2) @(negedge clk);
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        chk_eq("bump_idle", state, ST_IDLE);
        chk_eq("bump_motors", {drive_en, drive_sel}, 0);
        chk_eq("bump_jcnt_kept", junction_cnt, 1);

        // Reset mid-step drops motor ownership immediately
        restart(1'b0);
        expect_step(16'd240, 16'd120, 1'b0, 1'b1);
        ir = 8'h0F;
        wait_step("rstmid_pulse");
        ir = 8'h18;
        @(negedge clk);
        chk_eq("rstmid_sel_before", drive_sel, 1);
        rst = 1'b1;
        #1;
        chk_eq("rstmid_motors", {drive_en, drive_sel}, 0);
        chk_eq("rstmid_state", state, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;

        chk_eq("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
